// File: rtl/aes_axis_rx_pkg.sv
// Shared constants and state encoding for the AES AXI4-Stream receive front end.
// Optional build macro used by aes_axis_rx: AES_RX_ERR_EN.
package aes_axis_rx_pkg;

   localparam int WORD_S = 32;
   localparam int BLK_S  = 128;
   localparam int BYTE_S = 8;

   localparam logic [WORD_S-1:0] ENCRYPT = 32'h0000_0001;
   localparam logic [WORD_S-1:0] DECRYPT = 32'h0000_0002;
   localparam logic [WORD_S-1:0] SET_KEY = 32'h0000_0003;

   typedef enum logic [1:0] {
      AES_RX_CMD   = 2'd0,
      AES_RX_DATA  = 2'd1,
      AES_RX_START = 2'd2,
      AES_RX_BUSY  = 2'd3
   } aes_rx_state_t;

endpackage

// File: rtl/aes_word_packer.sv
// Packs stream words into blocks, word 0 in the most significant slot.
// A flush on a short block zero-fills the slots that were never written.
module aes_word_packer
   import aes_axis_rx_pkg::*;
#(
   parameter int WORD_W = WORD_S,
   parameter int BLK_W  = BLK_S,
   parameter int SLOTS  = BLK_W / WORD_W,
   parameter int IDX_W  = $clog2(SLOTS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic              flush,
   input  logic [WORD_W-1:0] word,
   output logic [IDX_W-1:0]  word_idx,
   output logic [BLK_W-1:0]  blk,
   output logic              blk_valid
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

   logic [WORD_W-1:0] slot [SLOTS];
   logic [BLK_W-1:0]  blk_nxt;

   always_comb begin
      blk_nxt = '0;
      for (int k = 0; k < SLOTS; k++) begin
         if (k < int'(word_idx))
            blk_nxt[BLK_W-1-k*WORD_W -: WORD_W] = slot[k];
         else if (k == int'(word_idx))
            blk_nxt[BLK_W-1-k*WORD_W -: WORD_W] = word;
      end
   end

   // slot contents are only ever read below word_idx, so they need no reset
   always_ff @(posedge clk) begin
      if (push)
         slot[word_idx] <= word;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_idx  <= '0;
         blk       <= '0;
         blk_valid <= 1'b0;
      end else begin
         blk_valid <= 1'b0;
         if (clear) begin
            word_idx <= '0;
         end else if (push) begin
            if (word_idx == LAST_IDX || flush) begin
               blk       <= blk_nxt;
               blk_valid <= 1'b1;
               word_idx  <= '0;
            end else begin
               word_idx <= word_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/aes_axis_rx.sv
// AXI4-Stream slave front end for aes_controller: command capture, block packing, FIFO write.
// Build option AES_RX_ERR_EN adds the sticky err_o flags (partial block, dropped block).
module aes_axis_rx
   import aes_axis_rx_pkg::*;
#(
   parameter int IN_FIFO_ADDR_WIDTH = 9,
   parameter int IN_FIFO_DATA_WIDTH = BLK_S,
   parameter int AXIS_DATA_WIDTH    = WORD_S
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic                          s_axis_tvalid,
   input  logic                          s_axis_tlast,
   output logic                          s_axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0]    aes_cmd,
   output logic [IN_FIFO_DATA_WIDTH-1:0] in_fifo_data,
   output logic                          in_fifo_w_e,
   output logic [IN_FIFO_ADDR_WIDTH-1:0] in_fifo_addr,
   output logic [IN_FIFO_ADDR_WIDTH-1:0] in_fifo_blk_cnt,
   output logic                          ctrl_en,
   input  logic                          ctrl_done
`ifdef AES_RX_ERR_EN
   ,
   output logic [1:0]                    err_o
`endif
);

   localparam int SLOTS = IN_FIFO_DATA_WIDTH / AXIS_DATA_WIDTH;
   localparam int IDX_W = $clog2(SLOTS);
   localparam logic [IN_FIFO_ADDR_WIDTH-1:0] BLK_MAX  = '1;
   localparam logic [IDX_W-1:0]              LAST_IDX = IDX_W'(SLOTS - 1);

   aes_rx_state_t state, state_nxt;

   logic                          hs;
   logic                          pack_push;
   logic                          rearm;
   logic                          tready_nxt;
   logic                          ctrl_en_nxt;
   logic                          full;
   logic                          blk_valid;
   logic [IDX_W-1:0]              word_idx;
   logic [IN_FIFO_ADDR_WIDTH-1:0] wr_ptr;

   assign hs    = s_axis_tvalid & s_axis_tready;
   assign rearm = (state == AES_RX_BUSY) & ctrl_done;
   assign full  = (in_fifo_blk_cnt == BLK_MAX);

   aes_word_packer #(
      .WORD_W (AXIS_DATA_WIDTH),
      .BLK_W  (IN_FIFO_DATA_WIDTH)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (rearm),
      .push      (pack_push),
      .flush     (s_axis_tlast),
      .word      (s_axis_tdata),
      .word_idx  (word_idx),
      .blk       (in_fifo_data),
      .blk_valid (blk_valid)
   );

   // once the FIFO is full, finished blocks are dropped but the stream keeps draining
   assign in_fifo_w_e  = blk_valid & ~full;
   assign in_fifo_addr = wr_ptr;

   always_comb begin
      state_nxt   = state;
      pack_push   = 1'b0;
      ctrl_en_nxt = 1'b0;
      case (state)
         AES_RX_CMD: begin
            if (hs)
               state_nxt = s_axis_tlast ? AES_RX_START : AES_RX_DATA;
         end
         AES_RX_DATA: begin
            if (hs) begin
               pack_push = 1'b1;
               if (s_axis_tlast)
                  state_nxt = AES_RX_START;
            end
         end
         AES_RX_START: begin
            // the final block is written during this cycle; start the controller after it
            state_nxt   = AES_RX_BUSY;
            ctrl_en_nxt = 1'b1;
         end
         AES_RX_BUSY: begin
            if (ctrl_done)
               state_nxt = AES_RX_CMD;
         end
         default: state_nxt = AES_RX_CMD;
      endcase
      tready_nxt = (state_nxt == AES_RX_CMD) || (state_nxt == AES_RX_DATA);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= AES_RX_CMD;
         s_axis_tready <= 1'b0;
         ctrl_en       <= 1'b0;
      end else begin
         state         <= state_nxt;
         s_axis_tready <= tready_nxt;
         ctrl_en       <= ctrl_en_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         aes_cmd         <= '0;
         wr_ptr          <= '0;
         in_fifo_blk_cnt <= '0;
      end else begin
         if (state == AES_RX_CMD && hs)
            aes_cmd <= s_axis_tdata;
         if (rearm) begin
            wr_ptr          <= '0;
            in_fifo_blk_cnt <= '0;
         end else if (in_fifo_w_e) begin
            wr_ptr          <= wr_ptr + 1'b1;
            in_fifo_blk_cnt <= in_fifo_blk_cnt + 1'b1;
         end
      end
   end

`ifdef AES_RX_ERR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err_o <= 2'b00;
      end else if (state == AES_RX_CMD && hs) begin
         err_o <= 2'b00;
      end else begin
         if (pack_push && s_axis_tlast && word_idx != LAST_IDX)
            err_o[0] <= 1'b1;
         if (blk_valid && full)
            err_o[1] <= 1'b1;
      end
   end
`else
   logic unused_err_src;
   assign unused_err_src = ^{word_idx, LAST_IDX};
`endif

endmodule

// File: tb/tb_aes_axis_rx.sv
// Randomized scoreboard bench for aes_axis_rx, built with a 2-bit FIFO address (3-block capacity).
module tb_aes_axis_rx;

   localparam int AW  = 2;
   localparam int CAP = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tready;
   logic [31:0]   aes_cmd;
   logic [127:0]  in_fifo_data;
   logic          in_fifo_w_e;
   logic [AW-1:0] in_fifo_addr;
   logic [AW-1:0] in_fifo_blk_cnt;
   logic          ctrl_en;
   logic          ctrl_done;
`ifdef AES_RX_ERR_EN
   logic [1:0]    err_o;
`endif

   aes_axis_rx #(.IN_FIFO_ADDR_WIDTH(AW)) dut (
      .clk             (clk),
      .reset           (reset),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tready   (s_axis_tready),
      .aes_cmd         (aes_cmd),
      .in_fifo_data    (in_fifo_data),
      .in_fifo_w_e     (in_fifo_w_e),
      .in_fifo_addr    (in_fifo_addr),
      .in_fifo_blk_cnt (in_fifo_blk_cnt),
      .ctrl_en         (ctrl_en),
      .ctrl_done       (ctrl_done)
`ifdef AES_RX_ERR_EN
      ,
      .err_o           (err_o)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int           exp_addr [$];
   logic [127:0] exp_data [$];
   logic [31:0]  exp_cmd  [$];
   int           exp_cnt  [$];
   logic [1:0]   exp_err  [$];
   bit           en_seen;
   int           en_cyc;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s got=timeout want=event", name);
   endtask

   // monitor: every FIFO write and every start pulse is matched against the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (in_fifo_w_e) begin
            if (exp_addr.size() == 0) begin
               chk("wr_unexpected", 128'(in_fifo_w_e), 128'(0));
            end else begin
               chk("wr_addr", 128'(in_fifo_addr), 128'(exp_addr.pop_front()));
               chk("wr_data", in_fifo_data, exp_data.pop_front());
            end
         end
         if (ctrl_en) begin
            if (exp_cmd.size() == 0) begin
               chk("en_unexpected", 128'(ctrl_en), 128'(0));
            end else begin
               chk("en_cmd", 128'(aes_cmd), 128'(exp_cmd.pop_front()));
               chk("en_blk_cnt", 128'(in_fifo_blk_cnt), 128'(exp_cnt.pop_front()));
`ifdef AES_RX_ERR_EN
               chk("err_o", 128'(err_o), 128'(exp_err.pop_front()));
`else
               void'(exp_err.pop_front());
`endif
            end
            en_seen = 1'b1;
            en_cyc  = cyc;
         end
      end
   end

   task automatic send_word(input logic [31:0] d, input bit last, input bit gaps,
                            input bit must_ready, output int hs_cyc);
      bit done;
      done   = 1'b0;
      hs_cyc = 0;
      if (gaps && $urandom_range(0, 1) == 1) begin
         s_axis_tvalid = 1'b0;
         repeat ($urandom_range(1, 2)) begin
            s_axis_tdata = $urandom;
            ctrl_done    = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            ctrl_done = 1'b0;
         end
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (must_ready && i == 0)
            chk("tready_no_stall", 128'(s_axis_tready), 128'(1));
         if (s_axis_tready) begin
            hs_cyc = cyc;
            done   = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done)
         timeout("handshake");
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   // reference: blocks are consecutive groups of four words, zero padded, only the first CAP stored
   task automatic run_pkt(input logic [31:0] cmd, input int n, input bit gaps);
      logic [31:0]  w [$];
      logic [127:0] b;
      int           nblk;
      int           hs_cyc;
      bit           busy_rdy;
      for (int i = 0; i < n; i++) w.push_back($urandom);
      nblk = (n + 3) / 4;
      for (int bi = 0; bi < nblk; bi++) begin
         b = '0;
         for (int k = 0; k < 4; k++)
            if (4 * bi + k < n) b[127 - 32 * k -: 32] = w[4 * bi + k];
         if (bi < CAP) begin
            exp_addr.push_back(bi);
            exp_data.push_back(b);
         end
      end
      exp_cmd.push_back(cmd);
      exp_cnt.push_back(nblk < CAP ? nblk : CAP);
      exp_err.push_back({nblk > CAP, (n % 4) != 0});
      en_seen = 1'b0;
      send_word(cmd, n == 0, gaps, 1'b1, hs_cyc);
      for (int i = 0; i < n; i++) send_word(w[i], i == n - 1, gaps, 1'b1, hs_cyc);
      for (int i = 0; i < 20 && !en_seen; i++) begin
         @(posedge clk);
         #1;
      end
      if (!en_seen) begin
         timeout("ctrl_en");
      end else begin
         chk("en_latency", 128'(en_cyc - hs_cyc), 128'(2));
         busy_rdy = 1'b0;
         repeat ($urandom_range(1, 5)) begin
            @(negedge clk);
            if (s_axis_tready) busy_rdy = 1'b1;
         end
         chk("tready_busy", 128'(busy_rdy), 128'(0));
         @(posedge clk);
         #1;
         ctrl_done = 1'b1;
         @(posedge clk);
         #1;
         ctrl_done = 1'b0;
         @(negedge clk);
         chk("tready_rearm", 128'(s_axis_tready), 128'(1));
         chk("blk_cnt_rearm", 128'(in_fifo_blk_cnt), 128'(0));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_tready", 128'(s_axis_tready), 128'(0));
      chk("rst_cmd", 128'(aes_cmd), 128'(0));
      chk("rst_w_e", 128'(in_fifo_w_e), 128'(0));
      chk("rst_addr", 128'(in_fifo_addr), 128'(0));
      chk("rst_blk_cnt", 128'(in_fifo_blk_cnt), 128'(0));
      chk("rst_ctrl_en", 128'(ctrl_en), 128'(0));
      chk("rst_data", in_fifo_data, 128'(0));
`ifdef AES_RX_ERR_EN
      chk("rst_err", 128'(err_o), 128'(0));
`endif
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("tready_after_reset", 128'(s_axis_tready), 128'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs_cyc;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      ctrl_done     = 1'b0;
      do_reset();

      run_pkt(32'h0000_0003, 4, 1'b0);   // key load, one full block
      run_pkt(32'h0000_0001, 12, 1'b1);  // three blocks with tvalid gaps
      run_pkt(32'h0000_0002, 6, 1'b0);   // trailing partial block
      run_pkt(32'h0000_0001, 20, 1'b0);  // overflow: two blocks dropped
      run_pkt(32'h0000_0001, 0, 1'b0);   // command only

      // reset in the middle of a packet, then a fresh packet must start at address 0
      send_word(32'h0000_0001, 1'b0, 1'b0, 1'b1, hs_cyc);
      send_word($urandom, 1'b0, 1'b0, 1'b1, hs_cyc);
      send_word($urandom, 1'b0, 1'b0, 1'b1, hs_cyc);
      do_reset();
      run_pkt(32'h0000_0003, 4, 1'b0);

      for (int p = 0; p < 25; p++)
         run_pkt($urandom, $urandom_range(0, 22), 1'($urandom_range(0, 1)));

      repeat (4) @(posedge clk);
      chk("wr_queue_drained", 128'(exp_addr.size()), 128'(0));
      chk("en_queue_drained", 128'(exp_cmd.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
